// File: rtl/jk_pkg.sv
// jk_pkg: shared state type, JK drive encodings and excitation helper for the JK driver.
package jk_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} jk_state_t;
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;
  // Returns {j,k}; prefer_toggle picks which don't-care encoding is used.
  function automatic logic [1:0] jk_excite(input logic q, input logic target, input logic prefer_toggle);
    return prefer_toggle ? (q == target ? (q ? JK_SET : JK_RESET) : JK_TOGGLE)
                         : (q == target ? JK_HOLD : (target ? JK_SET : JK_RESET));
  endfunction
endpackage

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: steers a JK flip-flop to a requested bit stream and checks its output.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter bit PREFER_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             clr_cnt,
  output logic             err,
  output logic             illegal,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] bit_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  jk_state_t state, state_nx;
  logic exp_bit, accept, fail;
  assign tgt_ready = state == IDLE && rst;
  assign accept    = state == IDLE && tgt_valid;
  assign fail      = q_in != exp_bit || q_in == qbar_in;
  always_comb state_nx = state == IDLE ? (tgt_valid ? DRIVE : IDLE) : (state == DRIVE ? CHECK : IDLE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // J/K are only non-hold for the single DRIVE cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s, r}  <= JK_HOLD;
      exp_bit <= 1'b0;
      err     <= 1'b0;
    end else begin
      {s, r}  <= accept ? jk_excite(q_in, tgt_bit, PREFER_TOGGLE) : JK_HOLD;
      exp_bit <= accept ? tgt_bit : exp_bit;
      err     <= state == CHECK && fail;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      illegal <= 1'b0;
      mis_cnt <= '0;
      bit_cnt <= '0;
    end else if (clr_cnt) begin
      illegal <= 1'b0;
      mis_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == CHECK) begin
      illegal <= illegal | (q_in == qbar_in);
      mis_cnt <= fail && mis_cnt != CNT_MAX ? mis_cnt + 1'b1 : mis_cnt;
      bit_cnt <= bit_cnt != CNT_MAX ? bit_cnt + 1'b1 : bit_cnt;
    end
endmodule
